// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam int BCD_W = 4;

    // True when DIGITS decimal digits can hold every BIN_W-bit unsigned value.
    function automatic bit digits_legal(input int bin_w, input int digits);
        longint p10;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        return p10 >= (longint'(1) << bin_w);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] nib,
    output logic [BCD_W-1:0] adj
);

    // Input never exceeds 9, so the 4-bit sum cannot overflow.
    assign adj = (nib >= BCD_W'(5)) ? nib + BCD_W'(3) : nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int SR_W    = BCD_TOT + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W + 1);

    generate
        if (!digits_legal(BIN_W, DIGITS)) begin : g_illegal
            $error("bin_to_bcd_seq: DIGITS=%0d cannot represent BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [SR_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_TOT-1:0] upper_adj;
    logic [SR_W-1:0]    adjusted;
    logic [SR_W-1:0]    shifted;

    // Adjust stage: correct every digit of the upper field, then shift left once.
    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_digit
            bcd_add3 u_add3 (
                .nib (shift_reg[BIN_W + BCD_W*d +: BCD_W]),
                .adj (upper_adj[BCD_W*d +: BCD_W])
            );
        end
    endgenerate

    assign adjusted = {upper_adj, shift_reg[BIN_W-1:0]};
    assign shifted  = adjusted << 1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= {{BCD_TOT{1'b0}}, bin};
                        cnt       <= CNT_W'(BIN_W);
                    end
                end
                CONVERT: begin
                    shift_reg <= shifted;
                    cnt       <= cnt - CNT_W'(1);
                    // Publish only the finished digits, never intermediate shifts.
                    if (cnt == CNT_W'(1)) begin
                        bcd_out <= shifted[SR_W-1:BIN_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: transaction-level model, directed cases, random traffic, 10-bit sweep.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    logic        start2;
    logic [9:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [15:0] bcd2;

    int tests  = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd_out(bcd_out)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd_out(bcd2)
    );

    // Decimal digits of v by repeated division, units in the low nibble.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request keeps the block busy for BIN_W+1 cycles, the last being done.
    int          m_rem = 0;
    int          m_val = 0;
    logic [11:0] m_bcd = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0;
            m_bcd = '0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem = 9;
                m_val = int'(bin);
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) m_bcd = to_bcd(m_val)[11:0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_rem != 0));
            check("done", 32'(done), 32'(m_rem == 1));
            check("bcd_out", 32'(bcd_out), 32'(m_bcd));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic convert(input logic [7:0] v);
        start = 1'b1;
        bin   = v;
        tick(1);
        start = 1'b0;
        tick(9);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int waited;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin    = '0;
        start2 = 1'b0;
        bin2   = '0;
        tick(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // bin=0: nine busy cycles, one done pulse.
        start = 1'b1;
        bin   = 8'd0;
        tick(1);
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            tick(1);
        end
        check("zero_busy_cycles", 32'(busy_cnt), 32'd9);
        check("zero_done_count", 32'(done_cnt), 32'd1);
        check("zero_bcd", 32'(bcd_out), 32'h000);

        convert(8'd255); check("lit_255", 32'(bcd_out), 32'h255);
        convert(8'd9);   check("lit_9", 32'(bcd_out), 32'h009);
        convert(8'd100); check("lit_100", 32'(bcd_out), 32'h100);

        // Requests during CONVERT and DONE are dropped; one in IDLE is taken.
        for (int c = 0; c < 20; c++) begin
            start = (c == 0) || (c == 3) || (c == 9) || (c == 10);
            bin   = (c == 0) ? 8'd42 : 8'd99;
            if (c == 10) check("overlap_42", 32'(bcd_out), 32'h042);
            tick(1);
        end
        check("idle_99", 32'(bcd_out), 32'h099);

        // Abort with reset during the 4th CONVERT cycle.
        convert(8'd255);
        start = 1'b1;
        bin   = 8'd17;
        tick(1);
        start = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h000);
        tick(12);

        // Continuous start: a conversion every 10 cycles.
        start = 1'b1;
        bin   = 8'd128;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done) done_cnt++;
        end
        start = 1'b0;
        check("repeat_done_count", 32'(done_cnt), 32'd4);
        check("repeat_bcd", 32'(bcd_out), 32'h128);
        tick(12);

        // Random traffic, including reset collisions.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            start = ($urandom_range(0, 2) == 0);
            bin   = 8'($urandom);
            tick(1);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick(12);

        // Exhaustive sweep on the 10-bit / 4-digit instance.
        for (int v = 0; v < 1024; v++) begin
            start2 = 1'b1;
            bin2   = 10'(v);
            tick(1);
            start2 = 1'b0;
            waited = 0;
            while (!done2 && waited < 20) begin
                tick(1);
                waited++;
            end
            if (!done2) begin
                check("sweep_timeout", 32'(v), 32'hFFFF_FFFF);
            end else begin
                check("sweep", 32'(bcd2), to_bcd(v) & 32'hFFFF);
            end
            tick(1);
        end
        check("lit_1023", 32'(bcd2), 32'h1023);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
